// File: rtl/eth_frame_splitter.sv
// Ethernet II frame splitter: parses dst/src/ethertype from the replay byte bus and
// streams the payload through a small FIFO with ready/valid output and pause backpressure.
module eth_frame_splitter #(
  parameter int FIFO_DEPTH   = 16,
  parameter int PAUSE_MARGIN = 4
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        available,
  input  logic        datavalid,
  input  logic [7:0]  data,
  output logic        pause,
  output logic        hdr_valid,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] ethertype,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] frame_count,
  output logic [15:0] runt_count,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PAUSE_LVL = CW'(FIFO_DEPTH - PAUSE_MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_synced;
  logic [3:0]    r_idx;
  logic [103:0]  r_hdr_sh;
  logic [111:0]  w_hdr;
  logic          r_hdr_valid;
  logic [47:0]   r_dst, r_src;
  logic [15:0]   r_type, r_frame_cnt, r_runt_cnt;
  logic [7:0]    r_hold_data;
  logic          r_hold_valid, r_hold_last;
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_overflow, r_pause;

  logic       w_accept, w_eof, w_hdr_done, w_runt, w_hold_load, w_hold_flush;
  logic       w_push, w_pop, w_full, w_wr;
  logic [8:0] w_push_word;

  // Until available has been seen low after reset we may be mid-frame, so stay deaf.
  assign w_accept = datavalid && ((r_state != S_IDLE) || (available && r_synced));
  assign w_eof    = !available && (r_state != S_IDLE);
  assign w_hdr    = {r_hdr_sh, data};

  // NOTE: every signal driven here gets a default first, otherwise paths that skip an
  // assignment infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_hdr_done   = 1'b0;
    w_runt       = 1'b0;
    w_hold_load  = 1'b0;
    w_hold_flush = 1'b0;
    w_push       = 1'b0;
    w_push_word  = '0;
    // A frame whose last byte arrived with EOF leaves it in hold; drain it now.
    if (r_hold_valid && r_hold_last) begin
      w_push       = 1'b1;
      w_push_word  = {1'b1, r_hold_data};
      w_hold_flush = 1'b1;
    end
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_HDR;
      S_HDR: begin
        if (w_accept && r_idx == 4'd13) begin
          w_hdr_done  = 1'b1;
          w_state_nxt = w_eof ? S_IDLE : S_PAYLOAD;
        end else if (w_eof) begin
          w_runt      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (w_accept) begin
          w_hold_load = 1'b1;
          if (r_hold_valid) begin
            w_push      = 1'b1;
            w_push_word = {1'b0, r_hold_data};
          end
        end else if (w_eof && r_hold_valid) begin
          w_push       = 1'b1;
          w_push_word  = {1'b1, r_hold_data};
          w_hold_flush = 1'b1;
        end
        if (w_eof) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_synced    <= 1'b0;
      r_idx       <= '0;
      r_hdr_sh    <= '0;
      r_hdr_valid <= 1'b0;
      r_dst       <= '0;
      r_src       <= '0;
      r_type      <= '0;
      r_frame_cnt <= '0;
      r_runt_cnt  <= '0;
    end else begin
      if (!available) r_synced <= 1'b1;
      if (w_state_nxt == S_IDLE)                      r_idx <= '0;
      else if (w_accept && r_state != S_PAYLOAD)      r_idx <= r_idx + 4'd1;
      if (w_accept && r_state != S_PAYLOAD) r_hdr_sh <= {r_hdr_sh[95:0], data};
      r_hdr_valid <= w_hdr_done;
      if (w_hdr_done) begin
        r_dst       <= w_hdr[111:64];
        r_src       <= w_hdr[63:16];
        r_type      <= w_hdr[15:0];
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_runt) r_runt_cnt <= r_runt_cnt + 16'd1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_hold_last  <= 1'b0;
    end else if (w_hold_load) begin
      r_hold_data  <= data;
      r_hold_valid <= 1'b1;
      r_hold_last  <= w_eof;
    end else if (w_hold_flush) begin
      r_hold_valid <= 1'b0;
      r_hold_last  <= 1'b0;
    end
  end

  assign w_full = (r_count == FULL_LVL);
  assign w_pop  = out_valid && out_ready;
  assign w_wr   = w_push && (!w_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_wr && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // NOTE: storage is left unreset; pointers and count alone define what is valid.
  always_ff @(posedge CLOCK) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_word;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_pause    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_pause <= (w_count_nxt >= PAUSE_LVL);
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  // Gate the read port so stale storage never shows while empty.
  assign out_valid   = (r_count != '0);
  assign out_data    = out_valid ? r_mem[r_rd_ptr][7:0] : 8'h00;
  assign out_last    = out_valid ? r_mem[r_rd_ptr][8]   : 1'b0;
  assign pause       = r_pause;
  assign hdr_valid   = r_hdr_valid;
  assign dst_mac     = r_dst;
  assign src_mac     = r_src;
  assign ethertype   = r_type;
  assign frame_count = r_frame_cnt;
  assign runt_count  = r_runt_cnt;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_eth_frame_splitter.sv
// Directed bench for eth_frame_splitter: header parse, runts, minimum frame, pause,
// overflow, mid-frame reset with resync and back-to-back frames.
module tb_eth_frame_splitter;

  logic        CLOCK, RESET_N, available, datavalid, out_ready;
  logic [7:0]  data;
  logic        pause, hdr_valid, out_valid, out_last, overflow;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] ethertype, frame_count, runt_count;
  logic [7:0]  out_data;

  eth_frame_splitter #(.FIFO_DEPTH(16), .PAUSE_MARGIN(4)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .available(available), .datavalid(datavalid),
    .data(data), .pause(pause), .hdr_valid(hdr_valid), .dst_mac(dst_mac),
    .src_mac(src_mac), .ethertype(ethertype), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .frame_count(frame_count), .runt_count(runt_count), .overflow(overflow)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int passed = 0;
  int total  = 0;

  logic [7:0]  frame_q[$];
  logic [7:0]  exp_q[$];
  logic        exp_last_q[$];
  logic [7:0]  rx_q[$];
  logic        rx_last_q[$];
  int          hdr_cnt;
  logic [47:0] cap_dst, cap_src;
  logic [15:0] cap_type;

  localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [47:0] SRC1  = 48'h00_11_22_33_44_55;

  always @(negedge CLOCK) begin
    if (RESET_N) begin
      if (out_valid && out_ready) begin
        rx_q.push_back(out_data);
        rx_last_q.push_back(out_last);
      end
      if (hdr_valid) begin
        hdr_cnt++;
        cap_dst  = dst_mac;
        cap_src  = src_mac;
        cap_type = ethertype;
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    rx_last_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    hdr_cnt = 0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; available = 1'b0; datavalid = 1'b0; data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    RESET_N = 1'b1;
    tick(); tick();
    clear_mon();
  endtask

  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] typ, input int n_pay, input logic [7:0] seed);
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back(src[47-8*i -: 8]);
    frame_q.push_back(typ[15:8]);
    frame_q.push_back(typ[7:0]);
    for (int i = 0; i < n_pay; i++) begin
      logic [7:0] b;
      b = seed + 8'(i * 7);
      frame_q.push_back(b);
      exp_q.push_back(b);
      exp_last_q.push_back(i == n_pay - 1);
    end
  endtask

  // eof_with_byte: final byte travels in the cycle where available drops.
  task automatic send_frame(input bit eof_with_byte);
    available = 1'b1;
    foreach (frame_q[i]) begin
      if (eof_with_byte && i == frame_q.size() - 1) available = 1'b0;
      datavalid = 1'b1;
      data      = frame_q[i];
      tick();
    end
    datavalid = 1'b0;
    data      = 8'h00;
    if (!eof_with_byte) begin
      available = 1'b0;
      tick();
    end
  endtask

  task automatic wait_rx(input int n);
    int k = 0;
    while (rx_q.size() < n && k < 400) begin
      tick();
      k++;
    end
    repeat (5) tick();
  endtask

  function automatic int stream_errs();
    int e = 0;
    if (rx_q.size() != exp_q.size()) return -1;
    foreach (exp_q[i])
      if (rx_q[i] !== exp_q[i] || rx_last_q[i] !== exp_last_q[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    logic [156:0] outs;
    RESET_N = 1'b0; available = 1'b0; datavalid = 1'b0; data = 8'h00; out_ready = 1'b1;
    @(negedge CLOCK);
    outs = {pause, hdr_valid, dst_mac, src_mac, ethertype, out_valid, out_data, out_last,
            frame_count, runt_count, overflow};
    total++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs); else passed++;
    do_reset();
  endtask

  task automatic test_normal_frame();
    int e;
    do_reset();
    out_ready = 1'b1;
    build_frame(BCAST, SRC1, 16'h0800, 46, 8'h10);
    send_frame(1'b0);
    wait_rx(46);
    total++;
    if (hdr_cnt !== 1) $display("FAIL t1_hdr_pulses: got %0d want 1", hdr_cnt); else passed++;
    total++;
    if ({cap_dst, cap_src, cap_type} !== {BCAST, SRC1, 16'h0800})
      $display("FAIL t1_fields: got %h %h %h want %h %h 0800", cap_dst, cap_src, cap_type, BCAST, SRC1);
    else passed++;
    total++;
    if (rx_q.size() !== 46) $display("FAIL t1_payload_len: got %0d want 46", rx_q.size()); else passed++;
    e = stream_errs();
    total++;
    if (e !== 0) $display("FAIL t1_payload_data_last: got %0d errors want 0", e); else passed++;
    total++;
    if ({frame_count, runt_count} !== {16'd1, 16'd0})
      $display("FAIL t1_counters: got frames %0d runts %0d want 1 0", frame_count, runt_count);
    else passed++;
  endtask

  task automatic test_runt();
    do_reset();
    out_ready = 1'b1;
    build_frame(BCAST, SRC1, 16'h0800, 0, 8'h00);
    repeat (4) void'(frame_q.pop_back());
    send_frame(1'b0);
    repeat (5) tick();
    total++;
    if (hdr_cnt !== 0 || rx_q.size() !== 0 || out_valid !== 1'b0)
      $display("FAIL t2_no_output: got hdr %0d bytes %0d out_valid %b want 0 0 0",
               hdr_cnt, rx_q.size(), out_valid);
    else passed++;
    total++;
    if ({frame_count, runt_count} !== {16'd0, 16'd1})
      $display("FAIL t2_counters: got frames %0d runts %0d want 0 1", frame_count, runt_count);
    else passed++;
  endtask

  task automatic test_min_frame();
    do_reset();
    out_ready = 1'b1;
    build_frame(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h88b5, 0, 8'h00);
    send_frame(1'b0);
    repeat (6) tick();
    total++;
    if (hdr_cnt !== 1 || cap_type !== 16'h88b5)
      $display("FAIL t3_hdr: got pulses %0d type %h want 1 88b5", hdr_cnt, cap_type);
    else passed++;
    total++;
    if (rx_q.size() !== 0) $display("FAIL t3_no_payload: got %0d want 0", rx_q.size()); else passed++;
    total++;
    if (frame_count !== 16'd1) $display("FAIL t3_frame_count: got %0d want 1", frame_count); else passed++;
  endtask

  task automatic test_pause();
    int i = 0, guard = 0, stall = 0, first_pause = -1, e;
    bit released = 0;
    do_reset();
    out_ready = 1'b0;
    build_frame(BCAST, SRC1, 16'h86dd, 86, 8'h03);
    available = 1'b1;
    while (i < 100 && guard < 3000) begin
      guard++;
      if (pause) begin
        datavalid = 1'b0;
        if (first_pause < 0) first_pause = i - 14;
        stall++;
        if (stall == 4 && !released) begin
          total++;
          if ({out_valid, out_data} !== {1'b1, frame_q[14]})
            $display("FAIL t4_stall_head: got %b %h want 1 %h", out_valid, out_data, frame_q[14]);
          else passed++;
          out_ready = 1'b1;
          released  = 1;
        end
      end else begin
        datavalid = 1'b1;
        data      = frame_q[i];
        i++;
      end
      tick();
    end
    datavalid = 1'b0;
    available = 1'b0;
    tick();
    total++;
    if (i !== 100) $display("FAIL t4_source_done: got %0d bytes sent want 100", i); else passed++;
    total++;
    if (first_pause !== 13)
      $display("FAIL t4_pause_point: got %0d payload bytes before pause want 13", first_pause);
    else passed++;
    wait_rx(86);
    total++;
    if (overflow !== 1'b0) $display("FAIL t4_overflow: got %b want 0", overflow); else passed++;
    e = stream_errs();
    total++;
    if (e !== 0) $display("FAIL t4_stream: got %0d errors (-1 = length %0d) want 0", e, rx_q.size());
    else passed++;
    total++;
    if (pause !== 1'b0) $display("FAIL t4_pause_release: got %b want 0", pause); else passed++;
  endtask

  task automatic test_overflow();
    int e;
    do_reset();
    out_ready = 1'b0;
    build_frame(BCAST, SRC1, 16'h0800, 86, 8'h40);
    while (exp_q.size() > 16) begin
      void'(exp_q.pop_back());
      void'(exp_last_q.pop_back());
    end
    available = 1'b1;
    foreach (frame_q[i]) begin
      if (i == 30) begin
        total++;
        if (overflow !== 1'b0) $display("FAIL t5_no_early_overflow: got %b want 0", overflow);
        else passed++;
      end
      datavalid = 1'b1;
      data      = frame_q[i];
      tick();
    end
    datavalid = 1'b0;
    available = 1'b0;
    tick();
    total++;
    if (overflow !== 1'b1) $display("FAIL t5_overflow_set: got %b want 1", overflow); else passed++;
    out_ready = 1'b1;
    wait_rx(16);
    e = stream_errs();
    total++;
    if (e !== 0) $display("FAIL t5_kept_bytes: got %0d errors (-1 = length %0d) want 0", e, rx_q.size());
    else passed++;
    total++;
    if (overflow !== 1'b1) $display("FAIL t5_overflow_sticky: got %b want 1", overflow); else passed++;
  endtask

  task automatic test_reset_back_to_back();
    logic [156:0] outs;
    int e;
    do_reset();
    out_ready = 1'b1;
    build_frame(BCAST, SRC1, 16'h0800, 46, 8'h77);
    available = 1'b1;
    for (int i = 0; i < 44; i++) begin
      datavalid = 1'b1;
      data      = frame_q[i];
      tick();
    end
    RESET_N = 1'b0;
    @(negedge CLOCK);
    outs = {pause, hdr_valid, dst_mac, src_mac, ethertype, out_valid, out_data, out_last,
            frame_count, runt_count, overflow};
    total++;
    if (outs !== '0) $display("FAIL t6_reset_outputs: got %h want 0", outs); else passed++;
    tick();
    RESET_N = 1'b1;
    data = 8'haa;
    repeat (4) tick();
    datavalid = 1'b0;
    available = 1'b0;
    tick();
    clear_mon();
    build_frame(48'h01_00_5e_00_00_01, 48'h0a_0b_0c_0d_0e_0f, 16'h0806, 6, 8'h21);
    send_frame(1'b1);
    build_frame(48'h66_55_44_33_22_11, 48'hde_ad_be_ef_00_01, 16'h8100, 16, 8'h90);
    send_frame(1'b0);
    wait_rx(22);
    total++;
    if (hdr_cnt !== 2) $display("FAIL t6_hdr_pulses: got %0d want 2", hdr_cnt); else passed++;
    total++;
    if ({cap_dst, cap_src, cap_type} !== {48'h66_55_44_33_22_11, 48'hde_ad_be_ef_00_01, 16'h8100})
      $display("FAIL t6_fields: got %h %h %h want 665544332211 deadbeef0001 8100",
               cap_dst, cap_src, cap_type);
    else passed++;
    total++;
    if ({frame_count, runt_count} !== {16'd2, 16'd0})
      $display("FAIL t6_counters: got frames %0d runts %0d want 2 0", frame_count, runt_count);
    else passed++;
    e = stream_errs();
    total++;
    if (e !== 0) $display("FAIL t6_stream: got %0d errors (-1 = length %0d) want 0", e, rx_q.size());
    else passed++;
  endtask

  initial begin
    RESET_N = 1'b0; available = 1'b0; datavalid = 1'b0; data = 8'h00; out_ready = 1'b0;
    hdr_cnt = 0;
    test_reset();
    test_normal_frame();
    test_runt();
    test_min_frame();
    test_pause();
    test_overflow();
    test_reset_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
